mac_feeder: RTL and testbench
=============================

Name: mac_feeder

Overview:
- Sequencer that drives the 4-lane MAC wrapper (mac_wrapper) and collects its result.
- Accepts a serial stream of (activation, weight) pairs and packs each 4 pairs into the lanes x0..x3 / w0..w3.
- Feeds the running partial sum back on psum_in and captures the wrapper's combinational out, accumulating over len groups.
- Presents the final dot product on a valid/ready output port.

Parameters:
- bw, 4, lane operand width (x unsigned, w signed two's complement).
- psum_bw, 16, partial-sum / result width.
- len_bw, 8, width of the group-count input.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a new dot product (sampled only in IDLE)
- len  in  len_bw  number of 4-pair groups, sampled with start
- in_valid  in  1  input pair valid
- in_ready  out  1  feeder accepts a pair this cycle
- in_x  in  bw  activation, unsigned
- in_w  in  bw  weight, signed
- x0,x1,x2,x3  out  bw  lane activations to the wrapper (registered)
- w0,w1,w2,w3  out  bw  lane weights to the wrapper (registered)
- psum_in  out  psum_bw  running accumulator to the wrapper (registered)
- mac_out  in  psum_bw  wrapper result: psum_in + sum(xi*wi), combinational
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_data  out  psum_bw  final dot product
- busy  out  1  high in any state other than IDLE
- chk_err  out  1  sticky self-check error (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): state=IDLE, all lane regs=0, acc (psum_in)=0, group count=0, lane index=0, in_ready=0, out_valid=0, out_data=0, busy=0, chk_err=0. Reset asserted mid-operation aborts immediately; no partial result is emitted.
- FSM states: IDLE, FILL, ISSUE, DONE.
- IDLE:
  - start=1: acc<=0, cnt<=0, lane index<=0, len latched.
  - Go to DONE if len==0, else go to FILL.
  - start is ignored in every other state.
- FILL:
  - in_ready=1.
  - On in_valid&&in_ready: write in_x/in_w into lane[idx], then idx++.
  - After the 4th accept (idx==3): go to ISSUE and reset idx to 0.
  - in_valid low stalls with no side effects.
- ISSUE (one cycle):
  - in_ready=0; lanes and psum_in are stable.
  - acc<=mac_out, cnt<=cnt+1.
  - Go to DONE if cnt+1==len, else go to FILL.
- DONE:
  - out_valid=1, out_data=acc.
  - On out_ready: go to IDLE, out_valid drops the next cycle.
  - out_ready low holds out_data stable indefinitely.
- Latency: 4 accept cycles + 1 ISSUE cycle per group. With no stalls, out_valid rises 5*len+1 cycles after start is sampled, or 1 cycle after start when len==0.
- Arithmetic:
  - Lane regs are not cleared between groups; all 4 are overwritten in each FILL.
  - acc wraps modulo 2^psum_bw; there is no saturation.
  - The feeder itself does no arithmetic; the wrapper defines the product sign rules (x zero-extended, w sign-extended).
- Lane outputs are driven directly from the lane registers. Values are only meaningful to the wrapper during ISSUE.

Optional Feature:
- Macro MAC_FEEDER_SELFCHECK_EN.
- Defined:
  - An internal reference computes acc + sum(zext(xi)*sext(wi)) mod 2^psum_bw.
  - In ISSUE, any mismatch with mac_out sets chk_err=1.
  - chk_err is sticky until reset or an accepted start.
- Undefined: chk_err is tied to 0 and no reference logic is built.

Test Plan:
- len=1, pairs (1,1),(2,2),(3,3),(4,4), back-to-back -> out_valid at cycle 6 after start, out_data=16'd30, busy=1 throughout.
- len=2, group1 as above, group2 four pairs (15,-8) -> out_data=30-480=-450=16'hFE3E (signed weight and wrap check).
- len=0 -> DONE next cycle, out_data=0, in_ready never asserted.
- Stalls: in_valid toggled every other cycle, out_ready held low 10 cycles -> same 16'd30 result, out_data stable while stalled, start pulses during busy ignored.
- Reset mid-FILL after 2 accepts, then a new len=1 run -> result depends only on the new pairs, all outputs 0 immediately on reset.
- SELFCHECK_EN defined, bench wrapper model corrupts mac_out by +1 -> chk_err=1 after ISSUE, stays 1, and clears on the next accepted start.

Source files
------------

// File: rtl/mac_feeder_if.sv
// Handshake and wrapper-lane bundle between mac_feeder (slave) and its environment (master).
interface mac_feeder_if #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned len_bw  = 8
);
    logic                start;
    logic [len_bw-1:0]   len;
    logic                in_valid;
    logic                in_ready;
    logic [bw-1:0]       in_x;
    logic [bw-1:0]       in_w;
    logic [bw-1:0]       x0, x1, x2, x3;
    logic [bw-1:0]       w0, w1, w2, w3;
    logic [psum_bw-1:0]  psum_in;
    logic [psum_bw-1:0]  mac_out;
    logic                out_valid;
    logic                out_ready;
    logic [psum_bw-1:0]  out_data;
    logic                busy;
    logic                chk_err;

    modport slave (
        input  start, len, in_valid, in_x, in_w, mac_out, out_ready,
        output in_ready, x0, x1, x2, x3, w0, w1, w2, w3, psum_in,
               out_valid, out_data, busy, chk_err
    );

    modport master (
        output start, len, in_valid, in_x, in_w, mac_out, out_ready,
        input  in_ready, x0, x1, x2, x3, w0, w1, w2, w3, psum_in,
               out_valid, out_data, busy, chk_err
    );
endinterface

// File: rtl/mac_feeder.sv
// Packs serial (x, w) pairs into 4 MAC lanes, accumulates wrapper results over len groups.
// Optional MAC_FEEDER_SELFCHECK_EN builds a reference that flags wrapper mismatches on chk_err.
module mac_feeder #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned len_bw  = 8
) (
    input logic         clk,
    input logic         reset_n,
    mac_feeder_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StFill, StIssue, StDone} state_t;

    state_t              state_q;
    logic [bw-1:0]       lane_x [4];
    logic [bw-1:0]       lane_w [4];
    logic [1:0]          idx_q;
    logic [len_bw-1:0]   cnt_q;
    logic [len_bw-1:0]   len_q;
    logic [psum_bw-1:0]  acc_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;
    logic [len_bw-1:0]   cnt_inc;

    assign cnt_inc = cnt_q + len_bw'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            for (int i = 0; i < 4; i++) begin
                lane_x[i] <= '0;
                lane_w[i] <= '0;
            end
            idx_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        idx_q  <= '0;
                        len_q  <= bus.len;
                        busy_q <= 1'b1;
                        if (bus.len == '0) begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= StFill;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                StFill: begin
                    if (bus.in_valid) begin
                        lane_x[idx_q] <= bus.in_x;
                        lane_w[idx_q] <= bus.in_w;
                        // 2-bit index wraps back to lane 0 after the 4th accept
                        idx_q         <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q    <= StIssue;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                StIssue: begin
                    acc_q <= bus.mac_out;
                    cnt_q <= cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q    <= StFill;
                        in_ready_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;
    assign bus.busy      = busy_q;
    assign bus.psum_in   = acc_q;
    assign bus.x0        = lane_x[0];
    assign bus.x1        = lane_x[1];
    assign bus.x2        = lane_x[2];
    assign bus.x3        = lane_x[3];
    assign bus.w0        = lane_w[0];
    assign bus.w1        = lane_w[1];
    assign bus.w2        = lane_w[2];
    assign bus.w3        = lane_w[3];

`ifdef MAC_FEEDER_SELFCHECK_EN
    logic [psum_bw-1:0] ref_sum;
    logic               chk_err_q;

    // Low psum_bw bits of the extended product are exact modulo 2^psum_bw.
    function automatic logic [psum_bw-1:0] lane_prod(input logic [bw-1:0] x,
                                                     input logic [bw-1:0] w);
        logic signed [psum_bw-1:0] xs;
        logic signed [psum_bw-1:0] ws;
        xs = $signed({{(psum_bw - bw){1'b0}}, x});
        ws = $signed({{(psum_bw - bw){w[bw-1]}}, w});
        return xs * ws;
    endfunction

    always_comb begin
        ref_sum = acc_q;
        for (int i = 0; i < 4; i++) begin
            ref_sum = ref_sum + lane_prod(lane_x[i], lane_w[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_err_q <= 1'b0;
        end else if (state_q == StIdle && bus.start) begin
            chk_err_q <= 1'b0;
        end else if (state_q == StIssue && ref_sum != bus.mac_out) begin
            chk_err_q <= 1'b1;
        end
    end

    assign bus.chk_err = chk_err_q;
`else
    assign bus.chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// Randomized scoreboard bench for mac_feeder with a behavioural MAC wrapper model.
module tb_mac_feeder;
    localparam int unsigned Bw     = 4;
    localparam int unsigned PsumBw = 16;
    localparam int unsigned LenBw  = 8;
`ifdef MAC_FEEDER_SELFCHECK_EN
    localparam bit SelfCheck = 1'b1;
`else
    localparam bit SelfCheck = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    bit          corrupt = 1'b0;
    bit          chk_expect = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          px[$];
    int          pw[$];
    logic [15:0] exp_q[$];

    mac_feeder_if #(.bw(Bw), .psum_bw(PsumBw), .len_bw(LenBw)) bus ();

    mac_feeder #(.bw(Bw), .psum_bw(PsumBw), .len_bw(LenBw)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Wrapper model: psum_in + sum(zext(x) * sext(w)), optionally off by one.
    always_comb begin
        int s;
        s = int'(bus.psum_in)
            + int'(bus.x0) * int'($signed(bus.w0)) + int'(bus.x1) * int'($signed(bus.w1))
            + int'(bus.x2) * int'($signed(bus.w2)) + int'(bus.x3) * int'($signed(bus.w3))
            + int'(corrupt);
        bus.mac_out = s[15:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Whole dot product over all pairs, reduced modulo 2^16 once at the end.
    function automatic logic [15:0] dot_ref(input int n);
        int s = 0;
        for (int k = 0; k < 4 * n; k++) s += px[k] * pw[k];
        return 16'(s);
    endfunction

    task automatic rand_pairs(input int n);
        px.delete();
        pw.delete();
        for (int k = 0; k < 4 * n; k++) begin
            px.push_back(int'($urandom_range(0, 15)));
            pw.push_back(int'($urandom_range(0, 15)) - 8);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
    task automatic do_run(input int n, input bit stall_in, input int out_hold, input bit spam);
        int          k = 0;
        int          cyc = 1;
        int          budget;
        bit          saw_ready = 1'b0;
        logic [15:0] exp_v;
        exp_v = dot_ref(n) + 16'(corrupt ? n : 0);
        exp_q.push_back(exp_v);
        check("chk_sticky", bus.chk_err, 32'(chk_expect));
        bus.start = 1'b1;
        bus.len   = LenBw'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("chk_clear", bus.chk_err, 0);
        check("busy_start", bus.busy, 1);
        budget = 12 * n + 20;
        while (!bus.out_valid && cyc < budget) begin
            if (k < 4 * n) begin
                bus.in_valid = stall_in ? 1'(cyc % 2) : 1'b1;
                bus.in_x     = 4'(px[k]);
                bus.in_w     = 4'(pw[k]);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (spam) bus.start = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_ready) saw_ready = 1'b1;
            if (bus.in_ready && bus.in_valid) k++;
            check("busy_run", bus.busy, 1);
            @(posedge clk); #1;
            cyc++;
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("done_reached", bus.out_valid, 1);
        if (!stall_in) check("latency", cyc, 5 * n + 1);
        check("pairs_used", k, 4 * n);
        if (n == 0) check("no_in_ready", saw_ready, 0);
        check("chk_err_done", bus.chk_err, 32'(SelfCheck && corrupt));
        chk_expect = SelfCheck && corrupt;
        repeat (out_hold) begin
            @(negedge clk);
            check("hold_data", bus.out_data, exp_v);
            check("hold_valid", bus.out_valid, 1);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("valid_drop", bus.out_valid, 0);
        check("busy_drop", bus.busy, 0);
    endtask

    // Scoreboard monitor: pops one expectation per result handshake.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("result", bus.out_data, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
        bus.in_x = '0; bus.in_w = '0; bus.out_ready = 1'b0;
        #12;
        check("rst_flags", {bus.in_ready, bus.out_valid, bus.busy, bus.chk_err}, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_psum", bus.psum_in, 0);
        check("rst_lanes", {bus.x0, bus.x1, bus.x2, bus.x3, bus.w0, bus.w1, bus.w2, bus.w3}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        px = {1, 2, 3, 4};
        pw = {1, 2, 3, 4};
        do_run(1, 1'b0, 0, 1'b0);

        px = {1, 2, 3, 4, 15, 15, 15, 15};
        pw = {1, 2, 3, 4, -8, -8, -8, -8};
        do_run(2, 1'b0, 2, 1'b0);

        px.delete(); pw.delete();
        do_run(0, 1'b0, 1, 1'b0);

        px = {1, 2, 3, 4};
        pw = {1, 2, 3, 4};
        do_run(1, 1'b1, 10, 1'b1);

        // Abort mid-fill after two accepts; no result may appear.
        px = {9, 10, 11, 12};
        pw = {3, -2, 5, -7};
        bus.start = 1'b1; bus.len = 8'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1; bus.in_x = 4'(px[i]); bus.in_w = 4'(pw[i]);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("abort_flags", {bus.in_ready, bus.out_valid, bus.busy, bus.chk_err}, 0);
        check("abort_out_data", bus.out_data, 0);
        check("abort_psum", bus.psum_in, 0);
        check("abort_lanes", {bus.x0, bus.x1, bus.x2, bus.x3, bus.w0, bus.w1, bus.w2, bus.w3}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_expect = 1'b0;
        @(posedge clk); #1;
        rand_pairs(1);
        do_run(1, 1'b0, 0, 1'b0);

        corrupt = 1'b1;
        rand_pairs(2);
        do_run(2, 1'b0, 3, 1'b0);
        corrupt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("chk_sticky_idle", bus.chk_err, 32'(SelfCheck));
        rand_pairs(1);
        do_run(1, 1'b0, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = int'($urandom_range(1, 5));
            rand_pairs(n);
            do_run(n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
